// File: rtl/bus_arb2.sv
// Two-host arbiter for a single-outstanding-transaction device, with a response watchdog.
// Define BUS_ARB_STRICT_PRIO_EN for fixed host0 priority; the default is round-robin.
module bus_arb2 #(
    parameter int unsigned TimeoutCycles = 16,
    parameter logic [31:0] ErrData       = 32'hBADC0FFE
) (
    input  logic        ck_i,
    input  logic        rst_i,
    input  logic        h0_req_i,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wd_i,
    output logic        h0_gnt_o,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rd_o,
    output logic        h0_err_o,
    input  logic        h1_req_i,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wd_i,
    output logic        h1_gnt_o,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rd_o,
    output logic        h1_err_o,
    output logic        dev_req_o,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wd_o,
    input  logic        dev_rvalid_i,
    input  logic [31:0] dev_rd_i
);

    localparam int unsigned TcntW = $clog2(TimeoutCycles + 1);
    localparam logic [TcntW-1:0] TcntLast = TcntW'(TimeoutCycles - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_gnt_q, last_gnt_d;
    logic [TcntW-1:0] tcnt_q, tcnt_d;

    logic             can_issue_s;
    logic             sel_s;
    logic             grant_s;
    logic             resp_s;
    logic             tmo_s;
    logic [31:0]      rd_s;

    // Arbitration: a new grant is possible when idle or when the current response completes.
    always_comb begin
        can_issue_s = (state_q == IDLE) | ((state_q == WAIT) & dev_rvalid_i);
        sel_s       = 1'b0;
        if (h0_req_i & h1_req_i) begin
`ifdef BUS_ARB_STRICT_PRIO_EN
            sel_s = 1'b0;
`else
            sel_s = ~last_gnt_q;
`endif
        end else if (h1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        grant_s = can_issue_s & (h0_req_i | h1_req_i) & ~rst_i;
        resp_s  = (state_q == WAIT) & dev_rvalid_i & ~rst_i;
        tmo_s   = (state_q == WAIT) & ~dev_rvalid_i & (tcnt_q == TcntLast) & ~rst_i;
        rd_s    = tmo_s ? ErrData : dev_rd_i;
    end

    // Next-state logic for the transaction sequencer and watchdog.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d    = WAIT;
                    owner_d    = sel_s;
                    last_gnt_d = sel_s;
                    tcnt_d     = {TcntW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (grant_s) begin
                    state_d    = WAIT;
                    owner_d    = sel_s;
                    last_gnt_d = sel_s;
                    tcnt_d     = {TcntW{1'b0}};
                end else if (dev_rvalid_i | tmo_s) begin
                    state_d = IDLE;
                    tcnt_d  = {TcntW{1'b0}};
                end else begin
                    tcnt_d = tcnt_q + TcntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tcnt_d  = {TcntW{1'b0}};
            end
        endcase
    end

    // State registers; reset discards any outstanding transaction.
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            tcnt_q     <= {TcntW{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Grant, device mux and response routing to the owning host.
    always_comb begin
        h0_gnt_o    = grant_s & ~sel_s;
        h1_gnt_o    = grant_s & sel_s;
        dev_req_o   = grant_s;
        dev_we_o    = 1'b0;
        dev_be_o    = 4'h0;
        dev_addr_o  = 32'h0000_0000;
        dev_wd_o    = 32'h0000_0000;
        if (grant_s & sel_s) begin
            dev_we_o   = h1_we_i;
            dev_be_o   = h1_be_i;
            dev_addr_o = h1_addr_i;
            dev_wd_o   = h1_wd_i;
        end else if (grant_s) begin
            dev_we_o   = h0_we_i;
            dev_be_o   = h0_be_i;
            dev_addr_o = h0_addr_i;
            dev_wd_o   = h0_wd_i;
        end else begin
            dev_we_o = 1'b0;
        end
        h0_rvalid_o = (resp_s | tmo_s) & ~owner_q;
        h1_rvalid_o = (resp_s | tmo_s) & owner_q;
        h0_err_o    = tmo_s & ~owner_q;
        h1_err_o    = tmo_s & owner_q;
        h0_rd_o     = 32'h0000_0000;
        h1_rd_o     = 32'h0000_0000;
        if (h0_rvalid_o) begin
            h0_rd_o = rd_s;
        end else if (h1_rvalid_o) begin
            h1_rd_o = rd_s;
        end else begin
            h0_rd_o = 32'h0000_0000;
        end
    end

endmodule
